// File: rtl/leve_pkg.sv
// Shared definitions for the leve2 decode stage: default sizes, instruction
// field positions and the operand/register-index types.
package leve_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NUM_REG_DEF = 32;
  localparam int MAX_NREAD   = 3;

  // Instruction field bit positions (each register field is 5 bits wide).
  localparam int RIDX_W  = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RS3_LSB = 27;

  typedef logic [RIDX_W-1:0] ridx_t;

  // Operand bundle for the widest configuration, index 0 = rs1.
  typedef logic [MAX_NREAD-1:0][XLEN_DEF-1:0] opnd_arr_t;

  // Source register index n (0 = rs1, 1 = rs2, 2 = rs3) of an instruction.
  function automatic ridx_t src_field(input logic [31:0] instr, input int n);
    case (n)
      0:       return instr[RS1_LSB +: RIDX_W];
      1:       return instr[RS2_LSB +: RIDX_W];
      default: return instr[RS3_LSB +: RIDX_W];
    endcase
  endfunction

  // Destination register index of an instruction.
  function automatic ridx_t rd_field(input logic [31:0] instr);
    return instr[RD_LSB +: RIDX_W];
  endfunction

endpackage

// File: rtl/leve2_regfile.sv
// Architectural register file: NREAD combinational read ports, one write
// port. x0 is hard-wired to zero and a same-cycle write is visible on reads.
// The storage is deliberately not reset.
module leve2_regfile
  import leve_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_REG = NUM_REG_DEF,
  parameter int NREAD   = 2
) (
  input  logic                        CLK,
  input  logic                        WE,
  input  ridx_t                       WA,
  input  logic [XLEN-1:0]             WD,
  input  ridx_t [NREAD-1:0]           RA,
  output logic [NREAD-1:0][XLEN-1:0]  RD
);

  logic [XLEN-1:0] mem [NUM_REG];

  // Write port; writes to x0 are dropped so x0 never holds data.
  always_ff @(posedge CLK) begin
    if (WE && (WA != '0)) begin
      mem[WA] <= WD;
    end
  end

  // Read ports with x0 forced to zero and write-through of the current write.
  always_comb begin
    RD = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (RA[i] == '0) begin
        RD[i] = '0;
      end else if (WE && (WA == RA[i])) begin
        RD[i] = WD;
      end else begin
        RD[i] = mem[RA[i]];
      end
    end
  end

endmodule

// File: rtl/leve2_id.sv
// Instruction decode stage: reads source operands (with EX and WB
// forwarding), detects load-use hazards against the instruction in EX and
// registers PC/instruction/operands toward EX.
//
// Handshake: a transfer on either side happens on a rising edge where
// valid and ready are both high in the preceding cycle. IF_READY is
// combinational and never depends on IF_VALID. OVALID, once high, stays
// high with stable OPC/OINSTR/RS until OREADY is seen, except that FLUSH
// or RST drops it.
module leve2_id
  import leve_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_REG = NUM_REG_DEF,
  parameter int NREAD   = 2,
  parameter int CNTW    = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        IF_VALID,
  output logic                        IF_READY,
  input  logic [XLEN-1:0]             IF_PC,
  input  logic [31:0]                 IF_INSTR,
  input  logic                        FLUSH,
  output logic                        OVALID,
  input  logic                        OREADY,
  output logic [XLEN-1:0]             OPC,
  output logic [31:0]                 OINSTR,
  output logic [NREAD-1:0][XLEN-1:0]  RS,
  input  logic                        EX_WE,
  input  logic                        EX_RD_VALID,
  input  logic [XLEN-1:0]             EX_RD,
  input  logic                        WB_WE,
  input  logic [4:0]                  WB_WA,
  input  logic [XLEN-1:0]             WB_RD,
  output logic [CNTW-1:0]             STALL_CNT
);

  ridx_t [NREAD-1:0]          src;
  ridx_t                      ex_rd;
  logic                       ex_fwd;
  logic                       src_hit;
  logic                       hazard;
  logic                       capture;
  logic [NREAD-1:0][XLEN-1:0] rf_rd;
  logic [NREAD-1:0][XLEN-1:0] opnd;

  // Source register indices of the instruction presented by fetch.
  always_comb begin
    src = '0;
    for (int i = 0; i < NREAD; i++) begin
      src[i] = src_field(IF_INSTR, i);
    end
  end

  leve2_regfile #(
    .XLEN    (XLEN),
    .NUM_REG (NUM_REG),
    .NREAD   (NREAD)
  ) u_regfile (
    .CLK (CLK),
    .WE  (WB_WE),
    .WA  (WB_WA),
    .WD  (WB_RD),
    .RA  (src),
    .RD  (rf_rd)
  );

  assign ex_rd  = rd_field(OINSTR);
  assign ex_fwd = OVALID && EX_WE;

  // Load-use hazard: EX will write a used source but has no result yet.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if (src[i] == ex_rd) begin
        src_hit = 1'b1;
      end
    end
    hazard = !RST && ex_fwd && (ex_rd != '0) && src_hit && !EX_RD_VALID;
  end

  assign IF_READY = RST || (!hazard && (!OVALID || OREADY));
  assign capture  = IF_VALID && IF_READY && !FLUSH;

  // Operand select: x0, then EX result, then the register file (which
  // already covers the WB write-through case).
  always_comb begin
    opnd = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (src[i] == '0) begin
        opnd[i] = '0;
      end else if (ex_fwd && (ex_rd == src[i])) begin
        opnd[i] = EX_RD;
      end else begin
        opnd[i] = rf_rd[i];
      end
    end
  end

  // Output register: flush beats capture beats hold; otherwise a bubble.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVALID <= 1'b0;
      OPC    <= '0;
      OINSTR <= '0;
      RS     <= '0;
    end else if (FLUSH) begin
      OVALID <= 1'b0;
    end else if (capture) begin
      OVALID <= 1'b1;
      OPC    <= IF_PC;
      OINSTR <= IF_INSTR;
      RS     <= opnd;
    end else if (OVALID && !OREADY) begin
      OVALID <= 1'b1;
    end else begin
      OVALID <= 1'b0;
    end
  end

  // Saturating count of cycles where fetch is held back by a hazard.
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CNT <= '0;
    end else if (IF_VALID && hazard && (STALL_CNT != '1)) begin
      STALL_CNT <= STALL_CNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_leve2_id.sv
// Bench for leve2_id (NREAD=3, 2-bit stall counter so saturation is
// reachable). A cycle model tracks architectural registers and the
// expected output register; directed scenarios add literal checks.
module tb_leve2_id;
  import leve_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREAD = 3;
  localparam int CNTW  = 2;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic                       IF_VALID;
  logic                       IF_READY;
  logic [XLEN-1:0]            IF_PC;
  logic [31:0]                IF_INSTR;
  logic                       FLUSH;
  logic                       OVALID;
  logic                       OREADY;
  logic [XLEN-1:0]            OPC;
  logic [31:0]                OINSTR;
  logic [NREAD-1:0][XLEN-1:0] RS;
  logic                       EX_WE;
  logic                       EX_RD_VALID;
  logic [XLEN-1:0]            EX_RD;
  logic                       WB_WE;
  logic [4:0]                 WB_WA;
  logic [XLEN-1:0]            WB_RD;
  logic [CNTW-1:0]            STALL_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  leve2_id #(
    .XLEN    (XLEN),
    .NUM_REG (32),
    .NREAD   (NREAD),
    .CNTW    (CNTW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IF_VALID    (IF_VALID),
    .IF_READY    (IF_READY),
    .IF_PC       (IF_PC),
    .IF_INSTR    (IF_INSTR),
    .FLUSH       (FLUSH),
    .OVALID      (OVALID),
    .OREADY      (OREADY),
    .OPC         (OPC),
    .OINSTR      (OINSTR),
    .RS          (RS),
    .EX_WE       (EX_WE),
    .EX_RD_VALID (EX_RD_VALID),
    .EX_RD       (EX_RD),
    .WB_WE       (WB_WE),
    .WB_WA       (WB_WA),
    .WB_RD       (WB_RD),
    .STALL_CNT   (STALL_CNT)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [4:0] rs3);
    return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [4:0] src_of(input logic [31:0] ins, input int i);
    if (i == 0) return ins[19:15];
    if (i == 1) return ins[24:20];
    return ins[31:27];
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0]     arf [32];
  bit              akn [32];
  logic            m_ovalid;
  logic [31:0]     m_opc;
  logic [31:0]     m_oinstr;
  opnd_arr_t       m_rs;
  bit [2:0]        m_rkn;
  bit              m_dchk;
  logic [CNTW-1:0] m_cnt;
  bit              m_init = 0;

  initial begin
    for (int r = 0; r < 32; r++) begin
      arf[r] = '0;
      akn[r] = 0;
    end
  end

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge CLK) begin
    logic [4:0] erd;
    logic [4:0] s;
    bit         hz;
    bit         cap;
    logic       exp_rdy;
    opnd_arr_t  n_rs;
    bit [2:0]   n_kn;

    erd = m_oinstr[11:7];
    hz  = 0;
    for (int i = 0; i < NREAD; i++) begin
      s = src_of(IF_INSTR, i);
      if (m_ovalid && EX_WE && erd != 0 && s == erd && !EX_RD_VALID) hz = 1;
    end
    exp_rdy = RST ? 1'b1 : (!hz && (!m_ovalid || OREADY));

    if (m_init) begin
      chk("m_if_ready", {31'b0, IF_READY}, {31'b0, exp_rdy});
      chk("m_ovalid", {31'b0, OVALID}, {31'b0, m_ovalid});
      chk("m_stall_cnt", {30'b0, STALL_CNT}, {30'b0, m_cnt});
      if (m_ovalid || m_dchk) begin
        chk("m_opc", OPC, m_opc);
        chk("m_oinstr", OINSTR, m_oinstr);
        for (int i = 0; i < NREAD; i++) begin
          if (m_rkn[i]) chk("m_rs", RS[i], m_rs[i]);
        end
      end
    end

    if (RST) begin
      m_ovalid = 0;
      m_opc    = '0;
      m_oinstr = '0;
      m_rs     = '0;
      m_rkn    = '1;
      m_dchk   = 1;
      m_cnt    = '0;
      m_init   = 1;
    end else begin
      if (IF_VALID && hz && m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
      cap  = IF_VALID && exp_rdy && !FLUSH;
      n_rs = '0;
      n_kn = '1;
      for (int i = 0; i < NREAD; i++) begin
        s = src_of(IF_INSTR, i);
        if (s == 0) n_rs[i] = '0;
        else if (m_ovalid && EX_WE && erd == s) n_rs[i] = EX_RD;
        else if (WB_WE && WB_WA == s) n_rs[i] = WB_RD;
        else begin
          n_rs[i] = arf[s];
          n_kn[i] = akn[s];
        end
      end
      if (FLUSH) begin
        m_ovalid = 0;
        m_dchk   = 0;
      end else if (cap) begin
        m_ovalid = 1;
        m_opc    = IF_PC;
        m_oinstr = IF_INSTR;
        m_rs     = n_rs;
        m_rkn    = n_kn;
        m_dchk   = 0;
      end else if (m_ovalid && !OREADY) begin
        m_ovalid = 1;
      end else begin
        m_ovalid = 0;
        m_dchk   = 0;
      end
    end
    if (WB_WE && WB_WA != 0) begin
      arf[WB_WA] = WB_RD;
      akn[WB_WA] = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    IF_VALID    = 0;
    IF_PC       = '0;
    IF_INSTR    = '0;
    FLUSH       = 0;
    OREADY      = 1;
    EX_WE       = 0;
    EX_RD_VALID = 0;
    EX_RD       = '0;
    WB_WE       = 0;
    WB_WA       = '0;
    WB_RD       = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    IF_VALID = 1;
    IF_PC    = pc;
    IF_INSTR = ins;
  endtask

  task automatic wb(input logic [4:0] wa, input logic [31:0] d);
    WB_WE = 1;
    WB_WA = wa;
    WB_RD = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    RST = 1;
    idle();
    repeat (3) cyc();
    chk("rst_if_ready", {31'b0, IF_READY}, 32'd1);
    chk("rst_ovalid", {31'b0, OVALID}, 32'd0);
    chk("rst_stall_cnt", {30'b0, STALL_CNT}, 32'd0);
    chk("rst_opc", OPC, 32'd0);
    RST = 0;

    // Seed x9 and x5.
    wb(5'd9, 32'h55);   cyc(); idle();
    wb(5'd5, 32'h1111); cyc(); idle();

    // Same-cycle WB and capture of x5.
    wb(5'd5, 32'h1234);
    fetch(32'h100, mk(5'd1, 5'd5, 5'd0, 5'd0));
    cyc(); idle();
    chk("wb_same_cycle_rs0", RS[0], 32'h1234);
    chk("cap_opc", OPC, 32'h100);
    chk("cap_ovalid", {31'b0, OVALID}, 32'd1);

    // Next-cycle read of x5 and rs3 read of x9.
    fetch(32'h104, mk(5'd2, 5'd5, 5'd0, 5'd9));
    cyc(); idle();
    chk("wb_next_cycle_rs0", RS[0], 32'h1234);
    chk("rs3_read", RS[2], 32'h55);

    // Write to x0 alongside a read of x0.
    wb(5'd0, 32'hFF);
    fetch(32'h108, mk(5'd3, 5'd0, 5'd0, 5'd0));
    cyc(); idle();
    chk("x0_same_cycle_rs0", RS[0], 32'h0);
    chk("x0_same_cycle_rs1", RS[1], 32'h0);

    // EX forwarding to rs2 with result available: no stall.
    fetch(32'h10C, mk(5'd4, 5'd0, 5'd3, 5'd0));
    EX_WE = 1; EX_RD_VALID = 1; EX_RD = 32'hAA;
    #1;
    chk("ex_fwd_ready", {31'b0, IF_READY}, 32'd1);
    cyc(); idle();
    chk("ex_fwd_rs1", RS[1], 32'hAA);
    chk("x0_after_wb", RS[0], 32'h0);
    chk("ex_fwd_no_stall", {30'b0, STALL_CNT}, 32'd0);

    // Load-use on x7: two stall cycles, then the forwarded result.
    fetch(32'h110, mk(5'd7, 5'd0, 5'd0, 5'd0));
    cyc(); idle();
    for (int k = 0; k < 2; k++) begin
      fetch(32'h200, mk(5'd8, 5'd7, 5'd0, 5'd0));
      EX_WE = 1; EX_RD_VALID = 0; OREADY = 0;
      #1;
      chk("load_use_ready", {31'b0, IF_READY}, 32'd0);
      cyc();
    end
    chk("load_use_cnt", {30'b0, STALL_CNT}, 32'd2);
    chk("load_use_hold_pc", OPC, 32'h110);
    EX_RD_VALID = 1; EX_RD = 32'h77; OREADY = 1;
    #1;
    chk("load_use_release", {31'b0, IF_READY}, 32'd1);
    cyc(); idle();
    chk("load_use_rs0", RS[0], 32'h77);
    chk("load_use_opc", OPC, 32'h200);

    // Backpressure, then FLUSH while held.
    fetch(32'h300, mk(5'd9, 5'd1, 5'd2, 5'd0));
    OREADY = 0;
    #1;
    chk("bp_ready", {31'b0, IF_READY}, 32'd0);
    cyc();
    chk("bp_hold_pc", OPC, 32'h200);
    chk("bp_hold_valid", {31'b0, OVALID}, 32'd1);
    FLUSH = 1;
    cyc();
    chk("flush_drop", {31'b0, OVALID}, 32'd0);
    FLUSH = 0;
    cyc();
    chk("after_flush_cap", OPC, 32'h300);
    idle();

    // Stall counter saturation, then reset in the middle of a stall.
    fetch(32'h400, mk(5'd10, 5'd9, 5'd0, 5'd0));
    EX_WE = 1; EX_RD_VALID = 0; OREADY = 0;
    cyc(); cyc();
    chk("stall_saturate", {30'b0, STALL_CNT}, 32'd3);
    RST = 1;
    #1;
    chk("rst_mid_ready", {31'b0, IF_READY}, 32'd1);
    cyc();
    RST = 0;
    chk("rst_mid_ovalid", {31'b0, OVALID}, 32'd0);
    chk("rst_mid_cnt", {30'b0, STALL_CNT}, 32'd0);
    #1;
    chk("rst_mid_no_hazard", {31'b0, IF_READY}, 32'd1);
    cyc(); idle();

    // Mixed traffic checked by the model alone.
    for (int k = 0; k < 40; k++) begin
      IF_VALID    = 1'($urandom_range(0, 1));
      IF_PC       = 32'h1000 + 32'(k * 4);
      IF_INSTR    = mk(5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                       5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
      FLUSH       = ($urandom_range(0, 7) == 0);
      OREADY      = 1'($urandom_range(0, 1));
      EX_WE       = 1'($urandom_range(0, 1));
      EX_RD_VALID = 1'($urandom_range(0, 1));
      EX_RD       = $urandom();
      WB_WE       = 1'($urandom_range(0, 1));
      WB_WA       = 5'($urandom_range(0, 9));
      WB_RD       = $urandom();
      cyc();
    end
    idle();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
